// File: rtl/extend_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : extend_unit_pkg
// Description : Shared FFT front-end constants, counter-width helper and the
//               occupancy encoding of the two-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package extend_unit_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int FRAME_LEN_DEF = 16;

    // A frame of two samples still needs one counter bit.
    function automatic int cnt_width(input int frame_len);
        return (frame_len > 2) ? $clog2(frame_len) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(FRAME_LEN_DEF);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage : extend_unit_pkg
`default_nettype wire

// File: rtl/extend_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_rstn_intrf / axi_ctr_intrf
// Description : Clock/reset bundle and AXI-stream control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_rstn_intrf;
    logic clk;
    logic rstn;

    modport master (output clk, output rstn);
    modport slave  (input  clk, input  rstn);
endinterface : clk_rstn_intrf

interface axi_ctr_intrf;
    logic tvalid;
    logic tready;
    logic tlast;

    modport s_axis (input  tvalid, input  tlast, output tready);
    modport m_axis (output tvalid, output tlast, input  tready);
    modport slave  (input  tvalid, input  tlast, output tready);
    modport master (output tvalid, output tlast, input  tready);
endinterface : axi_ctr_intrf
`default_nettype wire

// File: rtl/extend_unit_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer
// Description : Two-entry stream buffer (output register + skid register)
//               with a registered ready.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer
    import extend_unit_pkg::*;
#(
    parameter int data_w = 10
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              s_valid_i,
    output logic                   s_ready_o,
    input  wire logic [data_w-1:0] s_data_i,
    output logic                   m_valid_o,
    input  wire logic              m_ready_i,
    output logic      [data_w-1:0] m_data_o
);

    buf_state_e        state_q, state_d;
    logic [data_w-1:0] out_q,   out_d;
    logic [data_w-1:0] skid_q,  skid_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic              take;

    assign accept = s_valid_i && ready_q;
    assign take   = (state_q != BUF_EMPTY) && m_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    out_d   = s_data_i;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && take) begin
                    out_d   = s_data_i;
                end else if (accept) begin
                    skid_d  = s_data_i;
                    state_d = BUF_FULL;
                end else if (take) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                // ready is low here, so only the drain path can fire
                if (take) begin
                    out_d   = skid_q;
                    state_d = BUF_ONE;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
        ready_d = (state_d != BUF_FULL);
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = (state_q != BUF_EMPTY);
    assign m_data_o  = out_q;

endmodule : skid_buffer
`default_nettype wire

// File: rtl/extend_unit.sv
`default_nettype none
// ============================================================================
// Module      : extend_unit
// Description : Sign-extends stream samples by one bit and regenerates tlast
//               from a frame counter, flagging frame-length mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module extend_unit
    import extend_unit_pkg::*;
#(
    parameter int width     = WIDTH_DEF,
    parameter int frame_len = FRAME_LEN_DEF
) (
    clk_rstn_intrf.slave    clk_rstn_i,
    axi_ctr_intrf.s_axis    s_axis,
    axi_ctr_intrf.m_axis    m_axis,
    input  wire logic [width-1:0] data_i,
    output logic      [width:0]   data_o,
    output logic                  frame_err_o
);

    localparam int             CNT_W      = cnt_width(frame_len);
    localparam int             DATA_W     = width + 2;
    localparam logic [CNT_W-1:0] C_LAST_POS = CNT_W'(frame_len - 1);

    logic              clk;
    logic              rst_n;
    logic              in_ready;
    logic              accept;
    logic              last_pos;
    logic              tlast_flag;
    logic [DATA_W-1:0] buf_in;
    logic [DATA_W-1:0] buf_out;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              err_q,  err_d;

    assign clk   = clk_rstn_i.clk;
    assign rst_n = clk_rstn_i.rstn;

    assign accept     = s_axis.tvalid && in_ready;
    assign last_pos   = (cnt_q == C_LAST_POS);
    assign tlast_flag = s_axis.tlast || last_pos;
    assign buf_in     = {tlast_flag, data_i[width-1], data_i};

    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (accept) begin
            // Any emitted tlast (forced or from the source) starts a new frame
            cnt_d = tlast_flag ? '0 : cnt_q + 1'b1;
            err_d = (s_axis.tlast != last_pos);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    skid_buffer #(
        .data_w (DATA_W)
    ) u_skid_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid_i (s_axis.tvalid),
        .s_ready_o (in_ready),
        .s_data_i  (buf_in),
        .m_valid_o (m_axis.tvalid),
        .m_ready_i (m_axis.tready),
        .m_data_o  (buf_out)
    );

    assign s_axis.tready = in_ready;
    assign m_axis.tlast  = buf_out[DATA_W-1];
    assign data_o        = buf_out[width:0];
    assign frame_err_o   = err_q;

endmodule : extend_unit
`default_nettype wire

// File: tb/tb_extend_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_extend_unit
// Description : Directed scoreboard bench for extend_unit (width=8, frame_len=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_extend_unit;

    clk_rstn_intrf clk_if ();
    axi_ctr_intrf  s_if ();
    axi_ctr_intrf  m_if ();

    logic [7:0] data_i;
    logic [8:0] data_o;
    logic       frame_err_o;

    int n_cmp    = 0;
    int n_bad    = 0;
    int err_cnt  = 0;
    int err_base = 0;

    logic [9:0] sb[$];

    extend_unit #(
        .width     (8),
        .frame_len (4)
    ) dut (
        .clk_rstn_i  (clk_if),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .data_i      (data_i),
        .data_o      (data_o),
        .frame_err_o (frame_err_o)
    );

    initial clk_if.clk = 1'b0;
    always #5 clk_if.clk = ~clk_if.clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake
    always @(negedge clk_if.clk) begin
        if (clk_if.rstn) begin
            if (frame_err_o) err_cnt++;
            if (m_if.tvalid && m_if.tready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", {m_if.tlast, data_o});
                end else begin
                    check("out_beat", {22'b0, m_if.tlast, data_o}, {22'b0, sb.pop_front()});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_if.clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic [8:0] ed, input logic el);
        int   t;
        logic acc;
        t   = 0;
        acc = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tlast  = l;
        data_i      = d;
        do begin
            @(negedge clk_if.clk);
            acc = s_if.tready;
            cyc();
            t++;
        end while (!acc && t < 100);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        else      sb.push_back({el, ed});
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain_and_err(input string name, input int exp_err);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            cyc();
            t++;
        end
        repeat (2) cyc();
        check({name, "_drain"}, sb.size(), 0);
        check({name, "_frame_err"}, err_cnt - err_base, exp_err);
        err_base = err_cnt;
    endtask

    initial begin
        clk_if.rstn = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        data_i      = '0;
        repeat (3) cyc();
        check("rst_tready", s_if.tready, 0);
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tlast",  m_if.tlast,  0);
        check("rst_data",   data_o,      0);
        check("rst_err",    frame_err_o, 0);
        clk_if.rstn = 1'b1;
        cyc();
        check("rel_tready", s_if.tready, 1);

        // Sign extension, one-cycle latency
        m_if.tready = 1'b1;
        send(8'h7F, 1'b0, 9'h07F, 1'b0); check("lat1", {m_if.tvalid, data_o}, {1'b1, 9'h07F});
        send(8'h80, 1'b0, 9'h180, 1'b0); check("lat2", {m_if.tvalid, data_o}, {1'b1, 9'h180});
        send(8'hFF, 1'b0, 9'h1FF, 1'b0); check("lat3", {m_if.tvalid, data_o}, {1'b1, 9'h1FF});
        send(8'h00, 1'b1, 9'h000, 1'b1); check("lat4", {m_if.tvalid, data_o}, {1'b1, 9'h000});
        drain_and_err("signext", 0);

        // Normal frame
        send(8'h11, 1'b0, 9'h011, 1'b0);
        send(8'h22, 1'b0, 9'h022, 1'b0);
        send(8'h33, 1'b0, 9'h033, 1'b0);
        send(8'h44, 1'b1, 9'h044, 1'b1);
        drain_and_err("normal", 0);

        // Backpressure: A to output reg, B to skid, C held
        m_if.tready = 1'b0;
        send(8'h0A, 1'b0, 9'h00A, 1'b0);
        send(8'h0B, 1'b0, 9'h00B, 1'b0);
        check("bp_stall", s_if.tready, 0);
        s_if.tvalid = 1'b1;
        data_i      = 8'hC5;
        repeat (3) cyc();
        check("bp_held_ready", s_if.tready, 0);
        check("bp_held_out", {m_if.tvalid, data_o}, {1'b1, 9'h00A});
        m_if.tready = 1'b1;
        send(8'hC5, 1'b0, 9'h1C5, 1'b0);
        send(8'h0D, 1'b1, 9'h00D, 1'b1);
        drain_and_err("bp", 0);

        // Early tlast, then a full frame counted from position 0
        send(8'h01, 1'b0, 9'h001, 1'b0);
        send(8'h02, 1'b1, 9'h002, 1'b1);
        send(8'h03, 1'b0, 9'h003, 1'b0);
        send(8'h04, 1'b0, 9'h004, 1'b0);
        send(8'h05, 1'b0, 9'h005, 1'b0);
        send(8'h06, 1'b1, 9'h006, 1'b1);
        drain_and_err("early", 1);

        // Missing tlast
        send(8'h81, 1'b0, 9'h181, 1'b0);
        send(8'h82, 1'b0, 9'h182, 1'b0);
        send(8'h83, 1'b0, 9'h183, 1'b0);
        send(8'h84, 1'b0, 9'h184, 1'b1);
        drain_and_err("missing", 1);

        // Reset mid-frame with the skid register full
        m_if.tready = 1'b0;
        send(8'h21, 1'b0, 9'h021, 1'b0);
        send(8'h22, 1'b0, 9'h022, 1'b0);
        clk_if.rstn = 1'b0;
        #1;
        check("mid_rst_tready", s_if.tready, 0);
        check("mid_rst_tvalid", m_if.tvalid, 0);
        check("mid_rst_tlast",  m_if.tlast,  0);
        check("mid_rst_data",   data_o,      0);
        check("mid_rst_err",    frame_err_o, 0);
        sb.delete();
        repeat (2) cyc();
        err_base    = err_cnt;
        m_if.tready = 1'b1;
        clk_if.rstn = 1'b1;
        cyc();
        send(8'h31, 1'b0, 9'h031, 1'b0);
        send(8'h32, 1'b0, 9'h032, 1'b0);
        send(8'h33, 1'b0, 9'h033, 1'b0);
        send(8'h34, 1'b0, 9'h034, 1'b1);
        drain_and_err("post_rst", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_extend_unit
`default_nettype wire
